ccg_lut_eval: RTL
=================

CCG_LUT_EVAL -- requirements
Module: ccg_lut_eval

Interface
REQ-001 SHALL have parameter NUM_IN, default 3: number of primary inputs x; 1..8.
REQ-002 SHALL have parameter NUM_OUT, default 8: number of outputs f; 1..32.
REQ-003 SHALL have parameter CNT_W, default 16: width of the evaluation counter.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 SHALL have ports, one per line:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  truth-table write strobe
- cfg_addr  in  NUM_IN  table row, equal to the input vector x
- cfg_data  in  NUM_OUT  output bits for that row
- cfg_ready  out  1  a write is accepted this cycle
- in_valid  in  1  evaluation request
- in_ready  out  1  request accepted this cycle
- in_x  in  NUM_IN  input vector
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts the result
- out_x  out  NUM_IN  echo of the evaluated vector
- out_f  out  NUM_OUT  result, table[out_x]
- sweep_start  in  1  start exhaustive enumeration
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep completion
- eval_count  out  CNT_W  completed output handshakes

Function
REQ-006 SHALL hold a table of 2^NUM_IN rows x NUM_OUT bits in flops.
REQ-007 SHALL write cfg_data into row cfg_addr on a cycle where cfg_we and cfg_ready are both high; a cfg_we while cfg_ready is low SHALL be dropped.
REQ-008 SHALL drive cfg_ready = !sweep_busy.
REQ-009 SHALL drive in_ready = !sweep_busy && (!out_valid || out_ready).
REQ-010 SHALL, on an in_valid && in_ready handshake, load out_x = in_x and out_f = table[in_x], and set out_valid on the next edge; latency is 1 cycle.
REQ-011 SHALL sustain one result per cycle while out_ready is held high.
REQ-012 SHALL hold out_x and out_f stable while out_valid && !out_ready.
REQ-013 SHALL clear out_valid after an out_valid && out_ready handshake if no new load occurs in the same cycle.
REQ-014 SHALL, when a table write and an evaluation target the same row in the same cycle, return the pre-write contents; the new contents apply from the next cycle.
REQ-015 SHALL implement a state machine with states IDLE and SWEEP.
- IDLE -> SWEEP on sweep_start; the internal index is set to 0.
- In SWEEP, the index is loaded into the output stage under the same rule as REQ-009, with the sweep_busy term ignored; the index increments on each load.
- SWEEP -> IDLE on the load of index 2^NUM_IN-1, with a sweep_done pulse that same cycle.
REQ-016 SHALL ignore sweep_start while in SWEEP.
REQ-017 SHALL drive sweep_busy high exactly while the state is SWEEP.
REQ-018 SHALL increment eval_count on each out_valid && out_ready handshake and saturate at all-ones, with no wrap-around.

Reset
REQ-019 SHALL, on rst, clear the following:
- every table row to 0
- out_valid, out_x and out_f to 0
- eval_count to 0
- state to IDLE, with sweep_busy and sweep_done at 0
REQ-020 SHALL give rst priority over every other input; rst during SWEEP aborts the sweep with no sweep_done pulse, and the pending result is discarded.
REQ-021 SHALL drive in_ready and cfg_ready during reset according to their REQ-009 and REQ-008 equations applied to the reset state.

Configuration
REQ-022 SHALL support macro CCG_LUT_SWEEP_EN.
- When defined: sweep logic behaves as in REQ-015 to REQ-017.
- When undefined: no sweep logic is built, sweep_start is ignored, sweep_busy and sweep_done are tied to 0, and the port list is unchanged.

Verification
REQ-023 Bench SHALL use NUM_IN=3, NUM_OUT=8, and cover:
- Write row 5 = 0xA5, then send in_x=5 with out_ready=1 -> out_valid next cycle, out_f=0xA5, out_x=5, eval_count=1.
- Same-cycle write of row 2 = 0x3C and evaluation of in_x=2, with the row previously 0x00 -> out_f=0x00; a re-evaluation next cycle -> 0x3C.
- With out_ready=0, send in_x=1, then hold in_valid with in_x=4 -> in_ready=0 and out_f stable; raise out_ready -> result for row 1, then row 4 on the following cycle.
- Table loaded with row i = i*17, sweep_start, out_ready=1 -> out_x 0..7 on 8 consecutive cycles with out_f=i*17, sweep_done pulse on the 8th load, and cfg_we during the sweep dropped.
- rst asserted mid-sweep at index 3 -> next cycle state IDLE, out_valid=0, all rows 0, no sweep_done.
- CNT_W=2 with 5 handshakes -> eval_count stays at 3.
- Build without CCG_LUT_SWEEP_EN and pulse sweep_start -> sweep_busy=0 and in_ready unaffected.

Source files
------------

// File: rtl/ccg_lut_eval.sv
// ccg_lut_eval: flop-based truth-table evaluator.
// A 2^NUM_IN x NUM_OUT table is written through the cfg_* port and read
// through a single-entry valid/ready output stage with one cycle of latency.
// Optional exhaustive sweep of all table rows, built only when the macro
// CCG_LUT_SWEEP_EN is defined; otherwise sweep_start is ignored and
// sweep_busy/sweep_done are tied low.
//
// state  | meaning
// IDLE   | serving in_valid requests and table writes
// SWEEP  | feeding rows 0..2^NUM_IN-1 into the output stage; requests and writes blocked

module ccg_lut_eval #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [NUM_IN-1:0]  cfg_addr,
  input  logic [NUM_OUT-1:0] cfg_data,
  output logic               cfg_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_IN-1:0]  out_x,
  output logic [NUM_OUT-1:0] out_f,
  input  logic               sweep_start,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [CNT_W-1:0]   eval_count
);

  localparam int DEPTH = 1 << NUM_IN;

  logic [NUM_OUT-1:0] r_table [DEPTH];

  logic               r_out_valid;
  logic [NUM_IN-1:0]  r_out_x;
  logic [NUM_OUT-1:0] r_out_f;
  logic [CNT_W-1:0]   r_eval_count;

  logic               w_busy;
  logic               w_done;
  logic               w_sweep_load;
  logic [NUM_IN-1:0]  w_sweep_x;

  logic               w_stage_free;
  logic               w_out_fire;
  logic               w_in_load;
  logic               w_load;
  logic [NUM_IN-1:0]  w_load_x;
  logic               w_cfg_ready;
  logic               w_cfg_wr;

  // Output stage can take a new entry when empty or being drained this cycle.
  assign w_stage_free = !r_out_valid || out_ready;
  assign w_out_fire   = r_out_valid && out_ready;
  assign w_cfg_ready  = !w_busy;
  assign w_cfg_wr     = cfg_we && w_cfg_ready;
  assign w_in_load    = in_valid && !w_busy && w_stage_free;
  assign w_load       = w_in_load || w_sweep_load;
  assign w_load_x     = w_busy ? w_sweep_x : in_x;

`ifdef CCG_LUT_SWEEP_EN
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic [NUM_IN-1:0] LAST_IDX = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_IN-1:0] r_idx;
  logic [NUM_IN-1:0] w_idx_nxt;

  // Sweep state and row index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; a sweep row is loaded whenever the output stage can take it.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_sweep_load = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sweep_start) begin
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        if (w_stage_free) begin
          w_sweep_load = 1'b1;
          w_idx_nxt    = r_idx + NUM_IN'(1);
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_busy    = (r_state == ST_SWEEP);
  assign w_sweep_x = r_idx;
`else
  logic w_unused_sweep_start;

  assign w_busy               = 1'b0;
  assign w_done               = 1'b0;
  assign w_sweep_load         = 1'b0;
  assign w_sweep_x            = '0;
  assign w_unused_sweep_start = sweep_start;
`endif

  // Truth-table storage; a write never affects a read launched in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_cfg_wr) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // Single-entry output stage: load wins over drain so back-to-back results stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_f     <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_x     <= w_load_x;
      r_out_f     <= r_table[w_load_x];
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Completed-handshake counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eval_count <= '0;
    end else if (w_out_fire && (r_eval_count != '1)) begin
      r_eval_count <= r_eval_count + CNT_W'(1);
    end
  end

  assign cfg_ready  = w_cfg_ready;
  assign in_ready   = !w_busy && w_stage_free;
  assign out_valid  = r_out_valid;
  assign out_x      = r_out_x;
  assign out_f      = r_out_f;
  assign sweep_busy = w_busy;
  // A reset in the final sweep cycle aborts the sweep, so no completion pulse.
  assign sweep_done = w_done && !rst;
  assign eval_count = r_eval_count;

endmodule
